alu_multicycle: RTL and testbench

- Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller, plus two 32-bit operands.
- Logic, arithmetic and compare ops complete in one registered cycle.
- Shifts use an iterative shifter that moves SHIFT_STEP bits per cycle. This keeps the barrel shifter out of the critical path.
- Valid/ready handshakes on both sides let the datapath stall while a shift is in flight.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_iter_shifter.sv | 58 +++++
 rtl/alu_multicycle.sv | 107 ++++++++++
 tb/tb_alu_multicycle.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation encoding, FSM states and widths for the execute-stage ALU.
package alu_pkg;

    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_XOR = 4'b0001,
        OP_ADD = 4'b0010,
        OP_OR  = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SUB = 4'b0110,
        OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle until the loaded amount is consumed.
module alu_iter_shifter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  alu_op_e            op,
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done_c,
    output logic [XLEN-1:0]    next_c
);

    localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

    logic               busy;
    alu_op_e            kind;
    logic [XLEN-1:0]    work;
    logic [SHAMT_W-1:0] remaining;
    logic [SHAMT_W-1:0] step_c;

    // Final partial step uses whatever is left so the total never overshoots shamt.
    always_comb begin
        step_c = (remaining < STEP) ? remaining : STEP;
        next_c = work;
        case (kind)
            OP_SLL:  next_c = work << step_c;
            OP_SRL:  next_c = work >> step_c;
            OP_SRA:  next_c = $signed(work) >>> step_c;
            default: next_c = work;
        endcase
    end

    assign done_c = busy && (remaining <= STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            kind      <= OP_AND;
            work      <= '0;
            remaining <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            kind      <= op;
            work      <= data;
            remaining <= shamt;
        end else if (busy) begin
            work      <= next_c;
            remaining <= remaining - step_c;
            busy      <= !done_c;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative shifts, valid/ready on both sides.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      Operation,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero
);

    alu_state_e         state;
    alu_op_e            op;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               shift_long;
    logic [XLEN-1:0]    alu_c;
    logic               shift_done_c;
    logic [XLEN-1:0]    shift_next_c;

    assign op         = alu_op_e'(Operation);
    assign shamt      = SrcB[SHAMT_W-1:0];
    assign in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign shift_long = is_shift(op) && (shamt != '0);

    // Single-cycle result; a zero-amount shift simply passes SrcA through.
    always_comb begin
        alu_c = '0;
        case (op)
            OP_AND:  alu_c = SrcA & SrcB;
            OP_XOR:  alu_c = SrcA ^ SrcB;
            OP_ADD:  alu_c = SrcA + SrcB;
            OP_OR:   alu_c = SrcA | SrcB;
            OP_SUB:  alu_c = SrcA - SrcB;
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_c = SrcA;
            OP_EQ:   alu_c = XLEN'(SrcA == SrcB);
            OP_SLT:  alu_c = XLEN'($signed(SrcA) < $signed(SrcB));
            default: alu_c = '0;
        endcase
    end

    alu_iter_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && shift_long),
        .op     (op),
        .data   (SrcA),
        .shamt  (shamt),
        .done_c (shift_done_c),
        .next_c (shift_next_c)
    );

    // A new accept overrides the DONE->IDLE drain so back-to-back ops have no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (shift_done_c) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        ALUResult <= shift_next_c;
                        Zero      <= (shift_next_c == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (accept) begin
                if (shift_long) begin
                    state     <= ST_SHIFT;
                    out_valid <= 1'b0;
                end else begin
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                    ALUResult <= alu_c;
                    Zero      <= (alu_c == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle with one-bit and four-bit-per-cycle shifter instances.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid4;
    logic [3:0]  Operation;
    logic [31:0] SrcA, SrcB;
    logic        out_ready;
    logic        in_ready1, out_valid1, zero1;
    logic [31:0] result1;
    logic        in_ready4, out_valid4, zero4;
    logic [31:0] result4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid1), .out_ready(out_ready),
        .ALUResult(result1), .Zero(zero1)
    );

    alu_multicycle #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid4), .out_ready(out_ready),
        .ALUResult(result4), .Zero(zero4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
    endtask

    // Counts cycles from acceptance (cycle 1) until out_valid, bounded at 100.
    task automatic wait_out(input bit use4, output int cyc, output int ready_hi);
        cyc = 1;
        ready_hi = 0;
        while (((use4 ? out_valid4 : out_valid1) == 1'b0) && cyc < 100) begin
            if (use4 ? in_ready4 : in_ready1) ready_hi++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; in_valid4 = 1'b0;
        issue(OP_ADD, 32'h1, 32'h1);
        repeat (3) tick();
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid1); end
        checks++; if (result1 !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result1); end
        checks++; if (zero1 !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero1); end
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %b want 0", out_valid4); end
        in_valid = 1'b0; rst_n = 1'b1;
        tick();
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready1); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got %b want 0", out_valid1); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        tick();
        checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid1); end
        checks++; if (result1 !== 32'h0) begin errors++; $display("FAIL add_result: got %h want 00000000", result1); end
        checks++; if (zero1 !== 1'b1) begin errors++; $display("FAIL add_zero: got %b want 1", zero1); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready1); end
        issue(OP_SUB, 32'h5, 32'h7);
        tick();
        checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL sub_valid: got %b want 1", out_valid1); end
        checks++; if (result1 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result: got %h want fffffffe", result1); end
        checks++; if (zero1 !== 1'b0) begin errors++; $display("FAIL sub_zero: got %b want 0", zero1); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid1); end
    endtask

    task automatic test_sra();
        int cyc, ready_hi;
        out_ready = 1'b1;
        issue(OP_SRA, 32'h8000_0000, 32'd31);
        tick();
        in_valid = 1'b0;
        SrcA = 32'h0;  // must be ignored while busy
        wait_out(1'b0, cyc, ready_hi);
        checks++; if (cyc !== 32) begin errors++; $display("FAIL sra1_latency: got %0d want 32", cyc); end
        checks++; if (ready_hi !== 0) begin errors++; $display("FAIL sra1_in_ready: high %0d cycles want 0", ready_hi); end
        checks++; if (result1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra1_result: got %h want ffffffff", result1); end
        tick();
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL sra1_drain: got %b want 0", out_valid1); end

        Operation = OP_SRA; SrcA = 32'h8000_0000; SrcB = 32'd31; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        wait_out(1'b1, cyc, ready_hi);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL sra4_latency: got %0d want 9", cyc); end
        checks++; if (ready_hi !== 0) begin errors++; $display("FAIL sra4_in_ready: high %0d cycles want 0", ready_hi); end
        checks++; if (result4 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra4_result: got %h want ffffffff", result4); end
        tick();
    endtask

    task automatic test_sll();
        int cyc, ready_hi;
        out_ready = 1'b1;
        issue(OP_SLL, 32'h1, 32'h20);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL sll0_latency: got valid %b want 1", out_valid1); end
        checks++; if (result1 !== 32'h1) begin errors++; $display("FAIL sll0_result: got %h want 00000001", result1); end
        tick();
        issue(OP_SLL, 32'h1, 32'h1F);
        tick();
        in_valid = 1'b0;
        wait_out(1'b0, cyc, ready_hi);
        checks++; if (cyc !== 32) begin errors++; $display("FAIL sll31_latency: got %0d want 32", cyc); end
        checks++; if (result1 !== 32'h8000_0000) begin errors++; $display("FAIL sll31_result: got %h want 80000000", result1); end
        tick();
        issue(OP_SRL, 32'hF000_0000, 32'h3);
        tick();
        in_valid = 1'b0;
        wait_out(1'b0, cyc, ready_hi);
        checks++; if (result1 !== 32'h1E00_0000) begin errors++; $display("FAIL srl3_result: got %h want 1e000000", result1); end
        tick();
    endtask

    task automatic test_compare();
        out_ready = 1'b1;
        issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);
        tick();
        checks++; if (result1 !== 32'h1) begin errors++; $display("FAIL slt_result: got %h want 00000001", result1); end
        issue(OP_EQ, 32'h1234, 32'h1234);
        tick();
        checks++; if (result1 !== 32'h1) begin errors++; $display("FAIL eq_result: got %h want 00000001", result1); end
        checks++; if (zero1 !== 1'b0) begin errors++; $display("FAIL eq_zero: got %b want 0", zero1); end
        issue(OP_EQ, 32'h1234, 32'h1235);
        tick();
        checks++; if (result1 !== 32'h0) begin errors++; $display("FAIL neq_result: got %h want 00000000", result1); end
        issue(OP_OR, 32'hA0, 32'h0B);
        tick();
        checks++; if (result1 !== 32'hAB) begin errors++; $display("FAIL or_result: got %h want 000000ab", result1); end
        Operation = 4'b1111; SrcA = 32'hFF; SrcB = 32'h1;
        tick();
        checks++; if (result1 !== 32'h0 || zero1 !== 1'b1) begin errors++; $display("FAIL undef_op: got %h/%b want 00000000/1", result1, zero1); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(OP_XOR, 32'hF0, 32'hFF);
        tick();
        issue(OP_ADD, 32'h1, 32'h1);  // offered while stalled, must be ignored
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid1 !== 1'b1 || result1 !== 32'h0F) begin errors++; $display("FAIL hold_result[%0d]: got %b/%h want 1/0000000f", i, out_valid1, result1); end
            checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready1); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", out_valid1); end
    endtask

    task automatic test_abort();
        int seen = 0;
        out_ready = 1'b1;
        issue(OP_SRL, 32'hFFFF_FFFF, 32'd16);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        checks++; if (out_valid1 !== 1'b0 || result1 !== 32'h0 || zero1 !== 1'b1) begin errors++; $display("FAIL abort_reset: got %b/%h/%b want 0/00000000/1", out_valid1, result1, zero1); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b want 1", in_ready1); end
        for (int i = 0; i < 20; i++) begin
            if (out_valid1) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_reported: valid %0d cycles want 0", seen); end
        issue(OP_ADD, 32'h2, 32'h3);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid1 !== 1'b1 || result1 !== 32'h5) begin errors++; $display("FAIL post_abort_add: got %b/%h want 1/00000005", out_valid1, result1); end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sra();
        test_sll();
        test_compare();
        test_backpressure();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
